// File: rtl/serial_receive.sv
// Bit-serial line receiver: 2-FF synchronizer, mid-bit sampling FSM, and a
// one-entry valid/ready output buffer with frame-error and overrun pulses.
module serial_receive #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic                    s1_q, s2_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic                    bit_tick;
    logic                    load;
    logic                    stop_bad;
    logic [IDX_W-1:0]        wr_idx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_q        <= rxd;
            s2_q        <= s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // First received data bit lands at the top or bottom of the word
    always_comb begin
        wr_idx = MSB_FIRST ? (IDX_LAST - bit_idx_q) : bit_idx_q;
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = s2_q ? DATA : IDLE;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_tick) begin
                    cnt_d           = '0;
                    shift_d[wr_idx] = s2_q;
                    bit_idx_d       = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = s2_q ? WAIT_IDLE : IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bit_tick = (cnt_q == CNT_LAST);
        load     = (state_q == STOP) && bit_tick && !s2_q;
        stop_bad = (state_q == STOP) && bit_tick && s2_q;
        busy     = (state_q != IDLE);
    end

    // Output buffer: a completed word only overruns when the held word is not being taken
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;
        if (load) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_receive.sv
// Scoreboard bench for serial_receive: stimulus pushes expected words/pulses
// with their due cycle; a negedge monitor pops and compares on every DUT event.
module tb_serial_receive;

    localparam int DW  = 8;
    localparam int CPB = 16;
    localparam int LAT = 154;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          ready = 1'b1;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    serial_receive #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .MSB_FIRST    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t word_q[$];
    exp_t ferr_q[$];
    exp_t ovr_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: got unexpected event at cycle %0d, required none (data %0h)", name, cyc, data);
    endtask

    // Monitor: every handshake or pulse must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                if (word_q.size() == 0) unexpected("word");
                else begin
                    mon_e = word_q.pop_front();
                    check("word_data", {24'd0, data}, {24'd0, mon_e.data});
                    if (mon_e.at >= 0) check("word_cycle", cyc, mon_e.at);
                    $display("word %02h accepted at cycle %0d", data, cyc);
                end
            end
            if (frame_err === 1'b1) begin
                if (ferr_q.size() == 0) unexpected("frame_err");
                else begin
                    mon_e = ferr_q.pop_front();
                    check("frame_err_cycle", cyc, mon_e.at);
                    check("frame_err_valid", {31'd0, valid}, 32'd0);
                    $display("frame_err pulse at cycle %0d", cyc);
                end
            end
            if (overrun === 1'b1) begin
                if (ovr_q.size() == 0) unexpected("overrun");
                else begin
                    mon_e = ovr_q.pop_front();
                    check("overrun_cycle", cyc, mon_e.at);
                    check("overrun_held_data", {24'd0, data}, {24'd0, mon_e.data});
                    $display("overrun pulse at cycle %0d, held %02h", cyc, data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) tick(1);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop_bit);
        rxd = 1'b1;
        tick(CPB);
        for (int i = DW - 1; i >= 0; i--) begin
            rxd = w[i];
            tick(CPB);
        end
        rxd = stop_bit;
        tick(CPB);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},     {31'd0, valid},     32'd0);
        check({tag, "_data"},      {24'd0, data},      32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"},   {31'd0, overrun},   32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;

        // Reset held 3 cycles with the line high
        rst = 1'b1; rxd = 1'b1; ready = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0; rxd = 1'b0;
        tick(6);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Clean frame 0xA5, consumer always ready
        k = cyc + 1;
        word_q.push_back('{8'hA5, k + LAT});
        send_frame(8'hA5, 1'b0);
        rxd = 1'b0;
        tick(4);
        check("a5_valid_dropped", {31'd0, valid}, 32'd0);
        check("a5_data_held", {24'd0, data}, 32'hA5);

        // Short glitch: 4 cycles high
        k = cyc + 1;
        rxd = 1'b1;
        wait_edge(k + 1);
        check("glitch_busy_k1", {31'd0, busy}, 32'd0);
        wait_edge(k + 2);
        check("glitch_busy_k2", {31'd0, busy}, 32'd1);
        wait_edge(k + 3);
        rxd = 1'b0;
        wait_edge(k + 9);
        check("glitch_busy_k9", {31'd0, busy}, 32'd1);
        wait_edge(k + 10);
        check("glitch_busy_k10", {31'd0, busy}, 32'd0);
        tick(20);
        check("glitch_no_valid", {31'd0, valid}, 32'd0);

        // Frame 0x3C with bad stop, line stuck high for 40 more cycles
        k = cyc + 1;
        ferr_q.push_back('{8'h00, k + LAT});
        send_frame(8'h3C, 1'b1);
        tick(40);
        check("ferr_busy_wait", {31'd0, busy}, 32'd1);
        check("ferr_no_valid", {31'd0, valid}, 32'd0);
        rxd = 1'b0;
        tick(4);
        check("ferr_busy_released", {31'd0, busy}, 32'd0);
        tick(4);
        k = cyc + 1;
        word_q.push_back('{8'h3C, k + LAT});
        send_frame(8'h3C, 1'b0);
        rxd = 1'b0;
        tick(4);

        // Consumer stalled: 0x11 then 0x22 back-to-back, second one overruns
        ready = 1'b0;
        word_q.push_back('{8'h11, -1});
        send_frame(8'h11, 1'b0);
        k = cyc + 1;
        ovr_q.push_back('{8'h11, k + LAT});
        send_frame(8'h22, 1'b0);
        rxd = 1'b0;
        tick(4);
        check("stall_valid", {31'd0, valid}, 32'd1);
        check("stall_data", {24'd0, data}, 32'h11);
        ready = 1'b1;
        tick(1);
        check("release_valid", {31'd0, valid}, 32'd0);
        check("release_data", {24'd0, data}, 32'h11);
        tick(4);

        // Reset in the middle of DATA of frame 0xFF, then a clean 0x5A
        rxd = 1'b1;
        tick(CPB + 3 * CPB + CPB / 2);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1; rxd = 1'b0;
        tick(1);
        rst = 1'b0;
        check_reset_outputs("midreset");
        tick(20);
        check("abort_no_valid", {31'd0, valid}, 32'd0);
        k = cyc + 1;
        word_q.push_back('{8'h5A, k + LAT});
        send_frame(8'h5A, 1'b0);
        rxd = 1'b0;
        tick(10);

        check("pending_words", word_q.size(), 32'd0);
        check("pending_frame_err", ferr_q.size(), 32'd0);
        check("pending_overrun", ovr_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
